// File: rtl/seg7_mux2_pkg.sv
// Shared definitions for the two-digit multiplexed seven-segment driver:
// FSM state encoding and segment patterns (bit0=a .. bit6=g, 1 = lit).
package seg7_mux2_pkg;

  typedef enum logic [1:0] {
    SHOW_U = 2'd0,
    GAP_U  = 2'd1,
    SHOW_T = 2'd2,
    GAP_T  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_mux2_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import seg7_mux2_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_mux2.sv
// Two-digit time-multiplexed seven-segment driver with blanking gaps.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module seg7_mux2 #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);
  import seg7_mux2_pkg::*;

  localparam int MAX_DUR = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int TW      = (MAX_DUR > 2) ? $clog2(MAX_DUR) : 1;
  localparam logic [TW-1:0] SHOW_LOAD = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(BLANK_CYCLES - 1);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    units_q, units_d;
  logic [3:0]    tens_q, tens_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          frame_q, frame_d;
  logic [3:0]    digit_sel;
  logic [6:0]    digit_seg;

  // Outputs are computed from the next state so they switch on the same edge.
  bcd_to_seg7 u_dec (
    .bcd_i (digit_sel),
    .seg_o (digit_seg)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q - TW'(1);
    frame_d = 1'b0;
    if (timer_q == '0) begin
      case (state_q)
        SHOW_U:  begin state_d = GAP_U;  timer_d = GAP_LOAD;  end
        GAP_U:   begin state_d = SHOW_T; timer_d = SHOW_LOAD; end
        SHOW_T:  begin state_d = GAP_T;  timer_d = GAP_LOAD;  end
        default: begin state_d = SHOW_U; timer_d = SHOW_LOAD; frame_d = 1'b1; end
      endcase
    end

    units_d   = frame_d ? units : units_q;
    tens_d    = frame_d ? tens  : tens_q;
    digit_sel = (state_d == SHOW_T) ? tens_d : units_d;

    an_d  = 2'b00;
    seg_d = SEG_OFF;
    case (state_d)
      SHOW_U: begin an_d = 2'b01; seg_d = digit_seg; end
      SHOW_T: begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (tens_d != 4'd0) begin
          an_d  = 2'b10;
          seg_d = digit_seg;
        end
`else
        an_d  = 2'b10;
        seg_d = digit_seg;
`endif
      end
      default: begin an_d = 2'b00; seg_d = SEG_OFF; end
    endcase
  end

  // Pin polarity is folded into the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GAP_T;
      timer_q <= GAP_LOAD;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      frame_q <= 1'b0;
      an_q    <= {2{POL}};
      seg_q   <= SEG_OFF ^ {7{POL}};
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      frame_q <= frame_d;
      an_q    <= an_d ^ {2{POL}};
      seg_q   <= seg_d ^ {7{POL}};
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_mux2.sv
// Directed bench for seg7_mux2 with REFRESH_DIV=4, BLANK_CYCLES=2 (frame period 12);
// a second instance checks ACTIVE_LOW pin polarity.
module tb_seg7_mux2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] units = 4'd0;
  logic [3:0] tens  = 4'd0;
  logic [6:0] seg, seg_al;
  logic [1:0] an, an_al;
  logic       frame, frame_al;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_mux2 #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .units(units), .tens(tens),
    .seg(seg), .an(an), .frame(frame)
  );

  seg7_mux2 #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .units(units), .tens(tens),
    .seg(seg_al), .an(an_al), .frame(frame_al)
  );

  // Both digit enables must never be on together, on either instance.
  always @(negedge clk) begin
    checks = checks + 1;
    if (an === 2'b11 || an_al === 2'b00) begin
      failures = failures + 1;
      $display("FAIL an_onehot an=%b an_al=%b required not both on", an, an_al);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset two cycles, then release; the next tick is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    units = 4'd3;
    tens  = 4'd7;
    tick();
    tick();
    tick();
    checks = checks + 1;
    if (an !== 2'b00 || seg !== 7'h00 || frame !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_state an=%b seg=%h frame=%b required an=00 seg=00 frame=0", an, seg, frame);
    end
    checks = checks + 1;
    if (an_al !== 2'b11 || seg_al !== 7'h7F || frame_al !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_pins_al an=%b seg=%h frame=%b required an=11 seg=7f frame=0", an_al, seg_al, frame_al);
    end
  endtask

  task automatic test_sequence();
    logic [1:0] exp_an    [14] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                                   2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
    logic [6:0] exp_seg   [14] = '{7'h00, 7'h4F, 7'h4F, 7'h4F, 7'h4F, 7'h00, 7'h00,
                                   7'h07, 7'h07, 7'h07, 7'h07, 7'h00, 7'h00, 7'h4F};
    logic       exp_frame [14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    units = 4'd3;
    tens  = 4'd7;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick();
      checks = checks + 1;
      if (an !== exp_an[i] || seg !== exp_seg[i] || frame !== exp_frame[i]) begin
        failures = failures + 1;
        $display("FAIL sequence edge=%0d an=%b seg=%h frame=%b required an=%b seg=%h frame=%b",
                 i + 1, an, seg, frame, exp_an[i], exp_seg[i], exp_frame[i]);
      end
    end
  endtask

  task automatic test_hold();
    units = 4'd3;
    tens  = 4'd7;
    do_reset();
    repeat (8) tick();
    units = 4'd8;
    for (int e = 8; e <= 11; e++) begin
      checks = checks + 1;
      if (an !== 2'b10 || seg !== 7'h07) begin
        failures = failures + 1;
        $display("FAIL hold_show_t edge=%0d an=%b seg=%h required an=10 seg=07", e, an, seg);
      end
      tick();
    end
    tick();
    tick();
    checks = checks + 1;
    if (an !== 2'b01 || seg !== 7'h7F || frame !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL hold_next_frame an=%b seg=%h frame=%b required an=01 seg=7f frame=1", an, seg, frame);
    end
  endtask

  task automatic test_dash();
    units = 4'd12;
    tens  = 4'd15;
    do_reset();
    tick();
    tick();
    checks = checks + 1;
    if (an !== 2'b01 || seg !== 7'h40) begin
      failures = failures + 1;
      $display("FAIL dash_units an=%b seg=%h required an=01 seg=40", an, seg);
    end
    repeat (6) tick();
    checks = checks + 1;
    if (an !== 2'b10 || seg !== 7'h40) begin
      failures = failures + 1;
      $display("FAIL dash_tens an=%b seg=%h required an=10 seg=40", an, seg);
    end
  endtask

  task automatic test_leading_zero();
    logic [1:0] want_an;
    logic [6:0] want_seg;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    want_an  = 2'b00;
    want_seg = 7'h00;
`else
    want_an  = 2'b10;
    want_seg = 7'h3F;
`endif
    units = 4'd5;
    tens  = 4'd0;
    do_reset();
    tick();
    tick();
    checks = checks + 1;
    if (an !== 2'b01 || seg !== 7'h6D) begin
      failures = failures + 1;
      $display("FAIL lz_units an=%b seg=%h required an=01 seg=6d", an, seg);
    end
    repeat (6) tick();
    checks = checks + 1;
    if (an !== want_an || seg !== want_seg) begin
      failures = failures + 1;
      $display("FAIL lz_tens an=%b seg=%h required an=%b seg=%h", an, seg, want_an, want_seg);
    end
  endtask

  task automatic test_active_low();
    units = 4'd8;
    tens  = 4'd7;
    do_reset();
    tick();
    tick();
    checks = checks + 1;
    if (an_al !== 2'b10 || seg_al !== 7'h00 || frame_al !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL al_units an=%b seg=%h frame=%b required an=10 seg=00 frame=1", an_al, seg_al, frame_al);
    end
    repeat (4) tick();
    checks = checks + 1;
    if (an_al !== 2'b11 || seg_al !== 7'h7F) begin
      failures = failures + 1;
      $display("FAIL al_gap an=%b seg=%h required an=11 seg=7f", an_al, seg_al);
    end
    tick();
    tick();
    checks = checks + 1;
    if (an_al !== 2'b01 || seg_al !== 7'h78) begin
      failures = failures + 1;
      $display("FAIL al_tens an=%b seg=%h required an=01 seg=78", an_al, seg_al);
    end
  endtask

  task automatic test_reset_mid();
    units = 4'd3;
    tens  = 4'd7;
    do_reset();
    repeat (9) tick();
    rst = 1'b1;
    tick();
    checks = checks + 1;
    if (an !== 2'b00 || seg !== 7'h00 || frame !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL rst_mid_blank an=%b seg=%h frame=%b required an=00 seg=00 frame=0", an, seg, frame);
    end
    rst = 1'b0;
    tick();
    checks = checks + 1;
    if (an !== 2'b00 || frame !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL rst_mid_wait an=%b frame=%b required an=00 frame=0", an, frame);
    end
    tick();
    checks = checks + 1;
    if (an !== 2'b01 || seg !== 7'h4F || frame !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL rst_mid_restart an=%b seg=%h frame=%b required an=01 seg=4f frame=1", an, seg, frame);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_hold();
    test_dash();
    test_leading_zero();
    test_active_low();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
